// File: rtl/lockstep_commit_checker_if.sv
// Commit-record stream: one retired instruction per valid/ready handshake.
// The producer (core or golden model) uses the master modport, the checker
// uses the slave modport.
interface lockstep_commit_checker_if #(
   parameter int XLEN = 32
);
   logic            valid;
   logic            ready;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] instr;
   logic            regwrite;
   logic [4:0]      rd;
   logic [XLEN-1:0] wdata;
   logic            memwrite;
   logic [XLEN-1:0] memaddr;
   logic [XLEN-1:0] memwdata;

   modport master (
      output valid, pc, instr, regwrite, rd, wdata, memwrite, memaddr, memwdata,
      input  ready
   );

   modport slave (
      input  valid, pc, instr, regwrite, rd, wdata, memwrite, memaddr, memwdata,
      output ready
   );
endinterface

// File: rtl/lockstep_commit_checker.sv
// Lockstep commit checker: buffers commit records from a DUT core and a golden
// model in per-side FIFOs, pops head records in pairs, compares them field by
// field and reports a sticky PASS/FAIL status.
// Optional idle timeout enabled by defining LOCKSTEP_TIMEOUT_EN.

// Per-side record FIFO; head is registered storage, no fall-through.
module lockstep_commit_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // Pointer update; flush discards all buffered records.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Record storage; contents are only meaningful between the pointers.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

module lockstep_commit_checker #(
   parameter int              XLEN           = 32,
   parameter int              DEPTH          = 4,
   parameter int              SKIP_COMMITS   = 1,
   parameter logic [XLEN-1:0] DONE_ADDR      = 'h100,
   parameter logic [XLEN-1:0] DONE_DATA      = 'h1,
   parameter int              TIMEOUT_CYCLES = 20000
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       clear,
   lockstep_commit_checker_if.slave   dut,
   lockstep_commit_checker_if.slave   gold,
   output logic                       done,
   output logic                       pass,
   output logic                       fail,
   output logic [3:0]                 fail_code,
   output logic [XLEN-1:0]            fail_pc,
   output logic [31:0]                commit_count
);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            regwrite;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
      logic            memwrite;
      logic [XLEN-1:0] memaddr;
      logic [XLEN-1:0] memwdata;
   } rec_t;

   typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

   localparam int          REC_W    = $bits(rec_t);
   localparam logic [31:0] SKIP_LIM = 32'(SKIP_COMMITS);

   state_t          state, state_nxt;
   logic [3:0]      fail_code_nxt;
   logic [XLEN-1:0] fail_pc_nxt;
   logic [31:0]     skip_cnt;
   logic            compare_en;
   logic [3:0]      cmp_code;

   rec_t dut_rec, gold_rec, dut_head, gold_head;
   logic dut_full, dut_empty, gold_full, gold_empty;
   logic dut_push, gold_push, pop;
   logic timeout;

   // First failing field in priority order; rd==0 writes are treated as no write.
   function automatic logic [3:0] mismatch_code(input rec_t d, input rec_t g);
      logic       d_rw;
      logic       g_rw;
      logic [3:0] code;
      d_rw = d.regwrite && (d.rd != 5'd0);
      g_rw = g.regwrite && (g.rd != 5'd0);
      if (d.pc != g.pc)                             code = 4'd1;
      else if (d_rw != g_rw)                        code = 4'd2;
      else if (d_rw && (d.rd != g.rd))              code = 4'd3;
      else if (d_rw && (d.wdata != g.wdata))        code = 4'd4;
      else if (d.memwrite != g.memwrite)            code = 4'd5;
      else if (d.memwrite && (d.memaddr != g.memaddr))   code = 4'd6;
      else if (d.memwrite && (d.memwdata != g.memwdata)) code = 4'd7;
      else                                          code = 4'd0;
      return code;
   endfunction

   assign dut_rec  = '{pc: dut.pc, regwrite: dut.regwrite, rd: dut.rd, wdata: dut.wdata,
                       memwrite: dut.memwrite, memaddr: dut.memaddr, memwdata: dut.memwdata};
   assign gold_rec = '{pc: gold.pc, regwrite: gold.regwrite, rd: gold.rd, wdata: gold.wdata,
                       memwrite: gold.memwrite, memaddr: gold.memaddr, memwdata: gold.memwdata};

   assign dut.ready  = (state == ST_RUN) && !dut_full;
   assign gold.ready = (state == ST_RUN) && !gold_full;
   assign dut_push   = dut.valid && dut.ready;
   assign gold_push  = gold.valid && gold.ready;
   assign pop        = (state == ST_RUN) && !dut_empty && !gold_empty;
   assign compare_en = (skip_cnt >= SKIP_LIM);
   assign cmp_code   = mismatch_code(dut_head, gold_head);

   assign done = (state != ST_RUN);
   assign pass = (state == ST_PASS);
   assign fail = (state == ST_FAIL);

   lockstep_commit_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_dut_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (clear),
      .push    (dut_push),
      .pop     (pop),
      .wr_data (dut_rec),
      .full    (dut_full),
      .empty   (dut_empty),
      .head    (dut_head)
   );

   lockstep_commit_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_gold_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .flush   (clear),
      .push    (gold_push),
      .pop     (pop),
      .wr_data (gold_rec),
      .full    (gold_full),
      .empty   (gold_empty),
      .head    (gold_head)
   );

`ifdef LOCKSTEP_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // Idle counter: cycles in RUN since the last pair pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)               idle_cnt <= '0;
      else if (clear || pop)      idle_cnt <= '0;
      else if (state == ST_RUN)   idle_cnt <= idle_cnt + 1'b1;
   end

   assign timeout = (state == ST_RUN) && !pop && (idle_cnt >= 32'(TIMEOUT_CYCLES));
`else
   assign timeout = 1'b0;
`endif

   // Next-state/status: mismatch beats completion; timeout only when nothing popped.
   always_comb begin
      state_nxt     = state;
      fail_code_nxt = fail_code;
      fail_pc_nxt   = fail_pc;
      if (pop && compare_en) begin
         if (cmp_code != 4'd0) begin
            state_nxt     = ST_FAIL;
            fail_code_nxt = cmp_code;
            fail_pc_nxt   = dut_head.pc;
         end else if (dut_head.memwrite && (dut_head.memaddr == DONE_ADDR) &&
                      (dut_head.memwdata == DONE_DATA)) begin
            state_nxt = ST_PASS;
         end
      end else if (timeout) begin
         state_nxt     = ST_FAIL;
         fail_code_nxt = 4'd8;
         fail_pc_nxt   = '0;
      end
   end

   // Status registers, pop counter and saturating skip counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_RUN;
         fail_code    <= '0;
         fail_pc      <= '0;
         commit_count <= '0;
         skip_cnt     <= '0;
      end else if (clear) begin
         state        <= ST_RUN;
         fail_code    <= '0;
         fail_pc      <= '0;
         commit_count <= '0;
         skip_cnt     <= '0;
      end else begin
         state     <= state_nxt;
         fail_code <= fail_code_nxt;
         fail_pc   <= fail_pc_nxt;
         if (pop) commit_count <= commit_count + 1'b1;
         if (pop && !compare_en) skip_cnt <= skip_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_lockstep_commit_checker.sv
// Directed bench for lockstep_commit_checker: a table of commit pairs with
// hand-computed status after each pair, plus sequences for skew, async reset
// and (when LOCKSTEP_TIMEOUT_EN is defined) the idle timeout.
module tb_lockstep_commit_checker;
   localparam int XLEN = 32;

   logic              clock   = 1'b0;
   logic              reset_n = 1'b0;
   logic              clear   = 1'b0;
   logic              done, pass, fail;
   logic [3:0]        fail_code;
   logic [XLEN-1:0]   fail_pc;
   logic [31:0]       commit_count;

   lockstep_commit_checker_if #(.XLEN(XLEN)) dut_if ();
   lockstep_commit_checker_if #(.XLEN(XLEN)) gold_if ();

   lockstep_commit_checker #(
      .XLEN(XLEN), .DEPTH(4), .SKIP_COMMITS(1),
      .DONE_ADDR(32'h0000_0100), .DONE_DATA(32'h0000_0001), .TIMEOUT_CYCLES(50)
   ) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .clear        (clear),
      .dut          (dut_if),
      .gold         (gold_if),
      .done         (done),
      .pass         (pass),
      .fail         (fail),
      .fail_code    (fail_code),
      .fail_pc      (fail_pc),
      .commit_count (commit_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] pc;
      logic        regwrite;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic        memwrite;
      logic [31:0] memaddr;
      logic [31:0] memwdata;
   } trec_t;

   typedef struct {
      bit          clr;
      trec_t       d;
      trec_t       g;
      bit          efail;
      bit          epass;
      logic [3:0]  ecode;
      logic [31:0] epc;
      logic [31:0] ecnt;
   } vec_t;

   vec_t vt[$];
   int   n_chk = 0;
   int   n_mis = 0;

   function automatic trec_t mk(input logic [31:0] pc, input logic rw, input logic [4:0] rd,
                                input logic [31:0] wd, input logic mw = 1'b0,
                                input logic [31:0] ma = 32'h0, input logic [31:0] md = 32'h0);
      trec_t r;
      r = '{pc: pc, regwrite: rw, rd: rd, wdata: wd, memwrite: mw, memaddr: ma, memwdata: md};
      return r;
   endfunction

   function automatic vec_t mv(input bit clr, input trec_t d, input trec_t g, input bit ef,
                               input bit ep, input logic [3:0] ec, input logic [31:0] epc,
                               input logic [31:0] ecnt);
      vec_t v;
      v = '{clr: clr, d: d, g: g, efail: ef, epass: ep, ecode: ec, epc: epc, ecnt: ecnt};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic check_status(input string tag, input bit ef, input bit ep, input logic [3:0] ec,
                               input logic [31:0] epc, input logic [31:0] ecnt);
      chk({tag, ".done"}, 32'(done), 32'(ef | ep));
      chk({tag, ".pass"}, 32'(pass), 32'(ep));
      chk({tag, ".fail"}, 32'(fail), 32'(ef));
      chk({tag, ".code"}, 32'(fail_code), 32'(ec));
      chk({tag, ".pc"}, fail_pc, epc);
      chk({tag, ".cnt"}, commit_count, ecnt);
      chk({tag, ".dut_ready"}, 32'(dut_if.ready), 32'(!(ef | ep)));
      chk({tag, ".gold_ready"}, 32'(gold_if.ready), 32'(!(ef | ep)));
   endtask

   task automatic set_dut(input trec_t r, input logic v);
      dut_if.valid    = v;
      dut_if.pc       = r.pc;
      dut_if.instr    = r.pc ^ 32'h0000_0013;
      dut_if.regwrite = r.regwrite;
      dut_if.rd       = r.rd;
      dut_if.wdata    = r.wdata;
      dut_if.memwrite = r.memwrite;
      dut_if.memaddr  = r.memaddr;
      dut_if.memwdata = r.memwdata;
   endtask

   task automatic set_gold(input trec_t r, input logic v);
      gold_if.valid    = v;
      gold_if.pc       = r.pc;
      gold_if.instr    = r.pc ^ 32'h0000_0013;
      gold_if.regwrite = r.regwrite;
      gold_if.rd       = r.rd;
      gold_if.wdata    = r.wdata;
      gold_if.memwrite = r.memwrite;
      gold_if.memaddr  = r.memaddr;
      gold_if.memwdata = r.memwdata;
   endtask

   // Push one pair on the same edge, then land one negedge after the compare edge.
   task automatic apply_pair(input trec_t d, input trec_t g);
      @(negedge clock);
      set_dut(d, 1'b1);
      set_gold(g, 1'b1);
      @(negedge clock);
      dut_if.valid  = 1'b0;
      gold_if.valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic do_clear();
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      trec_t r;
      set_dut(mk(32'h0, 1'b0, 5'd0, 32'h0), 1'b0);
      set_gold(mk(32'h0, 1'b0, 5'd0, 32'h0), 1'b0);

      // Identical streams, one mid-run store to DONE_ADDR with the wrong data.
      for (int i = 0; i < 10; i++) begin
         r = mk(32'h1000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(3 * i));
         if (i == 5) r = mk(32'h1014, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'h2);
         if (i == 9) r = mk(32'h1024, 1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 32'h1);
         vt.push_back(mv(i == 0, r, r, 1'b0, i == 9, 4'd0, 32'h0, 32'(i + 1)));
      end
      // First pair skipped despite pc mismatch; second fails; third is frozen out.
      vt.push_back(mv(1, mk(32'h3000,1,1,1), mk(32'h3004,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h3008,1,1,1), mk(32'h300c,1,1,1), 1,0,4'd1,32'h3008,2));
      vt.push_back(mv(0, mk(32'h3010,1,1,1), mk(32'h3010,1,1,1), 1,0,4'd1,32'h3008,2));
      // Pair #3 wdata 5 vs 6.
      vt.push_back(mv(1, mk(32'h4000,1,1,1), mk(32'h4000,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h4004,1,2,2), mk(32'h4004,1,2,2), 0,0,4'd0,32'h0,2));
      vt.push_back(mv(0, mk(32'h4008,1,3,5), mk(32'h4008,1,3,6), 1,0,4'd4,32'h4008,3));
      // rd==0 write equals no write; then pc and memaddr both differ -> code 1.
      vt.push_back(mv(1, mk(32'h5000,1,1,1), mk(32'h5000,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h5004,1,0,7), mk(32'h5004,0,0,9), 0,0,4'd0,32'h0,2));
      vt.push_back(mv(0, mk(32'h5008,0,0,0,1,32'h200,1), mk(32'h500c,0,0,0,1,32'h204,1),
                      1,0,4'd1,32'h5008,3));
      // One segment per remaining failure code.
      vt.push_back(mv(1, mk(32'h6000,1,1,1), mk(32'h6000,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6004,1,5,1), mk(32'h6004,0,5,1), 1,0,4'd2,32'h6004,2));
      vt.push_back(mv(1, mk(32'h6100,1,1,1), mk(32'h6100,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6104,1,5,1), mk(32'h6104,1,6,1), 1,0,4'd3,32'h6104,2));
      vt.push_back(mv(1, mk(32'h6200,1,1,1), mk(32'h6200,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6204,0,0,0,1,32'h40,1), mk(32'h6204,0,0,0,0,32'h40,1),
                      1,0,4'd5,32'h6204,2));
      vt.push_back(mv(1, mk(32'h6300,1,1,1), mk(32'h6300,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6304,0,0,0,1,32'h40,1), mk(32'h6304,0,0,0,1,32'h44,1),
                      1,0,4'd6,32'h6304,2));
      vt.push_back(mv(1, mk(32'h6400,1,1,1), mk(32'h6400,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6404,0,0,0,1,32'h40,1), mk(32'h6404,0,0,0,1,32'h40,2),
                      1,0,4'd7,32'h6404,2));
      // Done store with a wdata mismatch on the same pair -> FAIL wins.
      vt.push_back(mv(1, mk(32'h6500,1,1,1), mk(32'h6500,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6504,1,2,5,1,32'h100,1), mk(32'h6504,1,2,6,1,32'h100,1),
                      1,0,4'd4,32'h6504,2));
      // Done store on a skipped pair is ignored; on a compared pair it passes.
      vt.push_back(mv(1, mk(32'h6600,0,0,0,1,32'h100,1), mk(32'h6600,0,0,0,1,32'h100,1),
                      0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6604,0,0,0,1,32'h100,1), mk(32'h6604,0,0,0,1,32'h100,1),
                      0,1,4'd0,32'h0,2));
      // rd==0 suppression together with completion.
      vt.push_back(mv(1, mk(32'h6700,1,1,1), mk(32'h6700,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6704,1,0,5,1,32'h100,1), mk(32'h6704,0,0,9,1,32'h100,1),
                      0,1,4'd0,32'h0,2));
      // Fields guarded by regwrite/memwrite are ignored when the flag is clear.
      vt.push_back(mv(1, mk(32'h6800,1,1,1), mk(32'h6800,1,1,1), 0,0,4'd0,32'h0,1));
      vt.push_back(mv(0, mk(32'h6804,0,3,1,0,32'h40,1), mk(32'h6804,0,4,2,0,32'h44,2),
                      0,0,4'd0,32'h0,2));

      // Reset state.
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_status("reset", 0, 0, 4'd0, 32'h0, 32'h0);

      // DUT leads by DEPTH records, a fifth is refused, then gold catches up.
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         set_dut(mk(32'h100 + 32'(4 * k), 1'b1, 5'(k + 1), 32'(k)), 1'b1);
      end
      @(negedge clock);
      chk("skew.dut_ready_full", 32'(dut_if.ready), 32'h0);
      chk("skew.gold_ready", 32'(gold_if.ready), 32'h1);
      set_dut(mk(32'h110, 1'b1, 5'd5, 32'd4), 1'b1);
      repeat (2) @(negedge clock);
      dut_if.valid = 1'b0;
      chk("skew.cnt_before", commit_count, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         set_gold(mk(32'h100 + 32'(4 * k), 1'b1, 5'(k + 1), 32'(k)), 1'b1);
      end
      @(negedge clock);
      gold_if.valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("skew.cnt_after", commit_count, 32'd4);
      chk("skew.fail", 32'(fail), 32'h0);
      chk("skew.dut_ready", 32'(dut_if.ready), 32'h1);

      // Table of pairs.
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].clr) begin
            do_clear();
            chk($sformatf("v%0d.clr_cnt", i), commit_count, 32'h0);
            chk($sformatf("v%0d.clr_done", i), 32'(done), 32'h0);
         end
         apply_pair(vt[i].d, vt[i].g);
         check_status($sformatf("v%0d", i), vt[i].efail, vt[i].epass, vt[i].ecode,
                      vt[i].epc, vt[i].ecnt);
      end

      // Async reset while in FAIL clears status immediately.
      do_clear();
      apply_pair(mk(32'h7000,1,1,1), mk(32'h7000,1,1,1));
      apply_pair(mk(32'h7004,1,1,1), mk(32'h7008,1,1,1));
      check_status("rst_pre", 1, 0, 4'd1, 32'h7004, 32'd2);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check_status("rst_async", 0, 0, 4'd0, 32'h0, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      // Async reset discards buffered DUT records.
      apply_pair(mk(32'h7100,1,1,1), mk(32'h7100,1,1,1));
      @(negedge clock);
      set_dut(mk(32'h7104,1,1,1), 1'b1);
      @(negedge clock);
      set_dut(mk(32'h7108,1,1,1), 1'b1);
      @(negedge clock);
      dut_if.valid = 1'b0;
      chk("rst_buf.cnt_pre", commit_count, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_buf.cnt_async", commit_count, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      set_gold(mk(32'h7104,1,1,1), 1'b1);
      @(negedge clock);
      gold_if.valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_buf.cnt_after", commit_count, 32'h0);
      chk("rst_buf.fail", 32'(fail), 32'h0);

`ifdef LOCKSTEP_TIMEOUT_EN
      // No gold pushes: idle timeout fires with code 8 and pc 0.
      do_clear();
      @(negedge clock);
      set_dut(mk(32'h8000,1,1,1), 1'b1);
      @(negedge clock);
      dut_if.valid = 1'b0;
      repeat (40) @(negedge clock);
      chk("tmo.early", 32'(fail), 32'h0);
      for (int c = 0; c < 100 && !fail; c++) @(negedge clock);
      check_status("tmo", 1, 0, 4'd8, 32'h0, 32'h0);
      do_clear();
      check_status("tmo_clr", 0, 0, 4'd0, 32'h0, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_mis);
      $finish;
   end
endmodule
